sparse_chunk_pingpong: RTL and testbench

SPARSE_CHUNK_PINGPONG -- requirements
Module: sparse_chunk_pingpong

---
 rtl/sparse_chunk_pingpong_if.sv | 57 +++++
 rtl/sparse_chunk_pingpong.sv | 151 +++++++++++++++
 tb/tb_sparse_chunk_pingpong.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_chunk_pingpong_if.sv
// Bundle of write, read, flush and debug signals for the sparse chunk ping-pong buffer.
// Slave is the buffer itself; master is the producer/consumer side.
interface sparse_chunk_pingpong_if #(
    parameter int MEM_SIZE        = 128,
    parameter int BUS_SIZE        = 16,
    parameter int PREFIX_SUM_SIZE = 8
);
    localparam int AW     = $clog2(MEM_SIZE) + 1;
    localparam int GROUPS = MEM_SIZE / PREFIX_SUM_SIZE;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int MW     = (PREFIX_SUM_SIZE > 1) ? $clog2(PREFIX_SUM_SIZE) : 1;
    localparam int BEATS  = MEM_SIZE / BUS_SIZE;
    localparam int BPW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                       refresh_mem_i;
    logic                       wr_valid_i;
    logic                       wr_ready_o;
    logic [BUS_SIZE-1:0]        wr_sparsemap_i;
    logic [BUS_SIZE*8-1:0]      wr_nonzero_data_i;
    logic                       rd_ready_o;
    logic [GW-1:0]              rd_sparsemap_addr_i;
    logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_o;
    logic [MW-1:0]              pri_enc_match_addr_i;
    logic                       rd_req_i;
    logic                       rd_valid_o;
    logic [7:0]                 rd_data_o;
    logic                       pri_enc_end_i;
    logic                       chunk_end_i;
    logic [AW-1:0]              rd_base_addr_o;

    // Debug view: {bank1_state, bank0_state}, bank selects, write pointers, read data address.
    logic [3:0]                 dbg_bank_state_o;
    logic                       dbg_wr_bank_o;
    logic                       dbg_rd_bank_o;
    logic [BPW-1:0]             dbg_wr_beat_o;
    logic [AW-1:0]              dbg_wr_ptr_o;
    logic [AW-1:0]              dbg_rd_addr_o;

    // Write beats transfer on the rising edge where wr_valid_i and wr_ready_o are both 1;
    // the producer holds the beat stable until then. Read requests are honoured only while
    // rd_ready_o is 1 and return rd_valid_o/rd_data_o exactly one cycle later.
    modport slave (
        input  refresh_mem_i, wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i,
        input  rd_sparsemap_addr_i, pri_enc_match_addr_i, rd_req_i, pri_enc_end_i, chunk_end_i,
        output wr_ready_o, rd_ready_o, rd_sparsemap_o, rd_valid_o, rd_data_o, rd_base_addr_o,
        output dbg_bank_state_o, dbg_wr_bank_o, dbg_rd_bank_o, dbg_wr_beat_o, dbg_wr_ptr_o,
        output dbg_rd_addr_o
    );

    modport master (
        output refresh_mem_i, wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i,
        output rd_sparsemap_addr_i, pri_enc_match_addr_i, rd_req_i, pri_enc_end_i, chunk_end_i,
        input  wr_ready_o, rd_ready_o, rd_sparsemap_o, rd_valid_o, rd_data_o, rd_base_addr_o,
        input  dbg_bank_state_o, dbg_wr_bank_o, dbg_rd_bank_o, dbg_wr_beat_o, dbg_wr_ptr_o,
        input  dbg_rd_addr_o
    );
endinterface

// File: rtl/sparse_chunk_pingpong.sv
// Two-bank ping-pong store of sparse chunks: one bank fills from packed nonzero beats
// while the other, once FULL, is read back by sparsemap group and match position.
module sparse_chunk_pingpong #(
    parameter int MEM_SIZE        = 128,
    parameter int BUS_SIZE        = 16,
    parameter int PREFIX_SUM_SIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sparse_chunk_pingpong_if.slave bus
);
    localparam int AW    = $clog2(MEM_SIZE) + 1;
    localparam int BEATS = MEM_SIZE / BUS_SIZE;
    localparam int BPW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]          r_bank_state [2];
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [BPW-1:0]      r_wr_beat;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_base;
    logic                r_rd_valid;
    logic [7:0]          r_rd_data;
    logic [MEM_SIZE-1:0] r_smap [2];
    logic [7:0]          r_data [2][MEM_SIZE];

    logic                       w_wr_ready;
    logic                       w_rd_ready;
    logic                       w_wr_fire;
    logic                       w_wr_last;
    logic                       w_rd_fire;
    logic [AW-1:0]              w_wr_pop;
    logic [AW-1:0]              w_wr_idx [BUS_SIZE];
    logic [PREFIX_SUM_SIZE-1:0] w_rd_smap;
    logic [AW-1:0]              w_rd_below;
    logic [AW-1:0]              w_rd_grp_pop;
    logic [AW-1:0]              w_rd_addr;
    logic                       w_match_bit;
    logic                       w_rd_in_range;
    logic [7:0]                 w_rd_byte;

    assign w_wr_ready = (r_bank_state[r_wr_bank] != ST_FULL);
    assign w_rd_ready = (r_bank_state[r_rd_bank] == ST_FULL);
    assign w_wr_fire  = bus.wr_valid_i & w_wr_ready;
    assign w_wr_last  = (r_wr_beat == BPW'(BEATS - 1));
    assign w_rd_fire  = bus.rd_req_i & w_rd_ready;

    assign w_rd_smap  = r_smap[r_rd_bank][int'(bus.rd_sparsemap_addr_i) * PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
    assign w_match_bit = w_rd_smap[bus.pri_enc_match_addr_i];
    assign w_rd_addr  = r_base + w_rd_below;
    // The extra address bit only flags an illegal overrun; such reads return zero.
    assign w_rd_in_range = ~w_rd_addr[AW-1];
    assign w_rd_byte  = r_data[r_rd_bank][w_rd_addr[AW-2:0]];

    always_comb begin
        w_wr_pop     = '0;
        w_rd_below   = '0;
        w_rd_grp_pop = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            w_wr_pop    = w_wr_pop + AW'(bus.wr_sparsemap_i[i]);
            w_wr_idx[i] = r_wr_ptr + AW'(i);
        end
        for (int i = 0; i < PREFIX_SUM_SIZE; i++) begin
            w_rd_grp_pop = w_rd_grp_pop + AW'(w_rd_smap[i]);
            if (i < int'(bus.pri_enc_match_addr_i)) begin
                w_rd_below = w_rd_below + AW'(w_rd_smap[i]);
            end
        end
    end

    // Storage arrays carry no reset; bank state alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire && !bus.refresh_mem_i) begin
            r_smap[r_wr_bank][int'(r_wr_beat) * BUS_SIZE +: BUS_SIZE] <= bus.wr_sparsemap_i;
            for (int k = 0; k < BUS_SIZE; k++) begin
                if ((AW'(k) < w_wr_pop) && !w_wr_idx[k][AW-1]) begin
                    r_data[r_wr_bank][w_wr_idx[k][AW-2:0]] <= bus.wr_nonzero_data_i[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bank_state[0] <= ST_EMPTY;
            r_bank_state[1] <= ST_EMPTY;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_wr_beat       <= '0;
            r_wr_ptr        <= '0;
            r_base          <= '0;
            r_rd_valid      <= 1'b0;
            r_rd_data       <= 8'h00;
        end else if (bus.refresh_mem_i) begin
            r_bank_state[0] <= ST_EMPTY;
            r_bank_state[1] <= ST_EMPTY;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_wr_beat       <= '0;
            r_wr_ptr        <= '0;
            r_base          <= '0;
            r_rd_valid      <= 1'b0;
            r_rd_data       <= 8'h00;
        end else begin
            // Write and read sides never touch the same bank in one cycle: a bank is
            // writable only when not FULL and readable only when FULL.
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_bank_state[r_wr_bank] <= ST_FULL;
                    r_wr_bank               <= ~r_wr_bank;
                    r_wr_beat               <= '0;
                    r_wr_ptr                <= '0;
                end else begin
                    r_bank_state[r_wr_bank] <= ST_FILL;
                    r_wr_beat               <= r_wr_beat + BPW'(1);
                    r_wr_ptr                <= r_wr_ptr + w_wr_pop;
                end
            end
            if (w_rd_ready) begin
                if (bus.chunk_end_i) begin
                    r_bank_state[r_rd_bank] <= ST_EMPTY;
                    r_rd_bank               <= ~r_rd_bank;
                    r_base                  <= '0;
                end else if (bus.pri_enc_end_i) begin
                    r_base <= r_base + w_rd_grp_pop;
                end
            end
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= (w_match_bit && w_rd_in_range) ? w_rd_byte : 8'h00;
            end
        end
    end

    assign bus.wr_ready_o       = w_wr_ready;
    assign bus.rd_ready_o       = w_rd_ready;
    assign bus.rd_sparsemap_o   = w_rd_smap;
    assign bus.rd_valid_o       = r_rd_valid;
    assign bus.rd_data_o        = r_rd_data;
    assign bus.rd_base_addr_o   = r_base;
    assign bus.dbg_bank_state_o = {r_bank_state[1], r_bank_state[0]};
    assign bus.dbg_wr_bank_o    = r_wr_bank;
    assign bus.dbg_rd_bank_o    = r_rd_bank;
    assign bus.dbg_wr_beat_o    = r_wr_beat;
    assign bus.dbg_wr_ptr_o     = r_wr_ptr;
    assign bus.dbg_rd_addr_o    = w_rd_addr;
endmodule

// File: tb/tb_sparse_chunk_pingpong.sv
// Directed bench for sparse_chunk_pingpong: read returns go through an expected queue
// checked by a monitor; control/status checks are made inline at the falling edge.
`timescale 1ns/1ps
module tb_sparse_chunk_pingpong;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q[$];

  sparse_chunk_pingpong_if bus ();

  sparse_chunk_pingpong dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every rd_valid_o pops one expected byte
  always @(negedge clk) begin
    if (bus.rd_valid_o === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, expected no return", bus.rd_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data_o !== e) begin
          n_fail++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", bus.rd_data_o, e);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [127:0] mk_data(input logic [7:0] first, input int n);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[k*8 +: 8] = first + 8'(k);
    return d;
  endfunction

  task automatic wr_beat(input logic [15:0] smap, input logic [127:0] data);
    bit acc;
    acc = 0;
    bus.wr_valid_i        = 1'b1;
    bus.wr_sparsemap_i    = smap;
    bus.wr_nonzero_data_i = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.wr_ready_o === 1'b1) begin
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL wr_timeout: got wr_ready 0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic wr_zero_beats(input int n);
    for (int i = 0; i < n; i++) wr_beat(16'h0000, '0);
  endtask

  task automatic rd_issue(input logic [3:0] grp, input logic [2:0] m, input logic [7:0] smap_exp,
                          input logic [7:0] addr_exp, input logic [7:0] data_exp);
    bus.rd_sparsemap_addr_i  = grp;
    bus.pri_enc_match_addr_i = m;
    bus.rd_req_i             = 1'b1;
    @(negedge clk);
    chk("rd_sparsemap", 32'(bus.rd_sparsemap_o), 32'(smap_exp));
    chk("rd_data_addr", 32'(bus.dbg_rd_addr_o), 32'(addr_exp));
    exp_q.push_back(data_exp);
    @(posedge clk); #1;
    bus.rd_req_i = 1'b0;
  endtask

  task automatic pulse_pri_end(input logic [3:0] grp);
    bus.rd_sparsemap_addr_i = grp;
    bus.pri_enc_end_i       = 1'b1;
    @(posedge clk); #1;
    bus.pri_enc_end_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_chunk_end();
    bus.chunk_end_i = 1'b1;
    @(posedge clk); #1;
    bus.chunk_end_i = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.refresh_mem_i        = 1'b0;
    bus.wr_valid_i           = 1'b0;
    bus.wr_sparsemap_i       = '0;
    bus.wr_nonzero_data_i    = '0;
    bus.rd_sparsemap_addr_i  = '0;
    bus.pri_enc_match_addr_i = '0;
    bus.rd_req_i             = 1'b0;
    bus.pri_enc_end_i        = 1'b0;
    bus.chunk_end_i          = 1'b0;

    // reset state
    #12;
    chk("rst_wr_ready",  32'(bus.wr_ready_o), 1);
    chk("rst_rd_ready",  32'(bus.rd_ready_o), 0);
    chk("rst_rd_valid",  32'(bus.rd_valid_o), 0);
    chk("rst_base",      32'(bus.rd_base_addr_o), 0);
    chk("rst_rd_data",   32'(bus.rd_data_o), 0);
    chk("rst_banks",     32'(bus.dbg_bank_state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8 dense-ish beats into bank 0
    for (int b = 0; b < 8; b++) wr_beat(16'h00FF, mk_data(8'h01, 8));
    @(negedge clk);
    chk("a_rd_ready", 32'(bus.rd_ready_o), 1);
    chk("a_wr_bank",  32'(bus.dbg_wr_bank_o), 1);
    chk("a_banks",    32'(bus.dbg_bank_state_o), 32'h2);
    @(posedge clk); #1;
    rd_issue(4'd0, 3'd3, 8'hFF, 8'd3, 8'h04);
    rd_issue(4'd1, 3'd5, 8'h00, 8'd0, 8'h00);
    pulse_pri_end(4'd0);
    chk("a_base_after_grp0", 32'(bus.rd_base_addr_o), 8);
    @(posedge clk); #1;
    rd_issue(4'd2, 3'd7, 8'hFF, 8'd15, 8'h08);
    pulse_chunk_end();
    chk("a_chunk_rd_ready", 32'(bus.rd_ready_o), 0);
    chk("a_chunk_rd_bank",  32'(bus.dbg_rd_bank_o), 1);
    chk("a_chunk_base",     32'(bus.rd_base_addr_o), 0);
    chk("a_chunk_banks",    32'(bus.dbg_bank_state_o), 0);
    @(posedge clk); #1;

    // bank 1: group 0 = A5, group 1 = 0F, data 10..17
    wr_beat(16'h0FA5, mk_data(8'h10, 8));
    wr_zero_beats(7);
    @(negedge clk);
    chk("b_rd_ready", 32'(bus.rd_ready_o), 1);
    @(posedge clk); #1;
    rd_issue(4'd0, 3'd2, 8'hA5, 8'd1, 8'h11);
    rd_issue(4'd0, 3'd1, 8'hA5, 8'd1, 8'h00);
    pulse_pri_end(4'd0);
    chk("b_base_after_A5", 32'(bus.rd_base_addr_o), 4);
    @(posedge clk); #1;
    rd_issue(4'd1, 3'd2, 8'h0F, 8'd6, 8'h16);
    pulse_chunk_end();
    chk("b_chunk_rd_bank", 32'(bus.dbg_rd_bank_o), 0);
    // ends ignored while nothing is FULL
    @(posedge clk); #1;
    pulse_pri_end(4'd0);
    chk("idle_pri_end_ignored", 32'(bus.rd_base_addr_o), 0);
    @(posedge clk); #1;
    pulse_chunk_end();
    chk("idle_chunk_end_ignored", 32'(bus.dbg_rd_bank_o), 0);
    @(posedge clk); #1;

    // 16 beats with no reads: both banks FULL
    wr_zero_beats(16);
    @(negedge clk);
    chk("c_wr_ready_full", 32'(bus.wr_ready_o), 0);
    chk("c_banks_full",    32'(bus.dbg_bank_state_o), 32'hA);
    @(posedge clk); #1;
    // beat held while stalled must not land
    bus.wr_valid_i        = 1'b1;
    bus.wr_sparsemap_i    = 16'h0003;
    bus.wr_nonzero_data_i = mk_data(8'hC1, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("c_stall_beat", 32'(bus.dbg_wr_beat_o), 0);
    chk("c_stall_ptr",  32'(bus.dbg_wr_ptr_o), 0);
    @(posedge clk); #1;
    pulse_chunk_end();
    chk("c_chunk_wr_ready", 32'(bus.wr_ready_o), 1);
    chk("c_chunk_rd_ready", 32'(bus.rd_ready_o), 1);
    chk("c_chunk_rd_bank",  32'(bus.dbg_rd_bank_o), 1);
    chk("c_chunk_base",     32'(bus.rd_base_addr_o), 0);
    @(posedge clk); #1;
    bus.wr_valid_i = 1'b0;
    @(negedge clk);
    chk("c_held_beat_taken", 32'(bus.dbg_wr_beat_o), 1);
    chk("c_held_ptr",        32'(bus.dbg_wr_ptr_o), 2);
    chk("c_banks_fill",      32'(bus.dbg_bank_state_o), 32'h9);
    @(posedge clk); #1;

    // last beat of bank 0 together with chunk_end releasing bank 1
    wr_zero_beats(6);
    bus.wr_valid_i        = 1'b1;
    bus.wr_sparsemap_i    = 16'h0000;
    bus.wr_nonzero_data_i = '0;
    bus.chunk_end_i       = 1'b1;
    @(posedge clk); #1;
    bus.wr_valid_i  = 1'b0;
    bus.chunk_end_i = 1'b0;
    @(negedge clk);
    chk("d_banks",    32'(bus.dbg_bank_state_o), 32'h2);
    chk("d_rd_bank",  32'(bus.dbg_rd_bank_o), 0);
    chk("d_wr_bank",  32'(bus.dbg_wr_bank_o), 1);
    @(posedge clk); #1;
    rd_issue(4'd0, 3'd1, 8'h03, 8'd1, 8'hC2);

    // refresh with chunk_end and rd_req in the same cycle
    wr_zero_beats(3);
    @(negedge clk);
    chk("e_pre_beat", 32'(bus.dbg_wr_beat_o), 3);
    @(posedge clk); #1;
    bus.refresh_mem_i        = 1'b1;
    bus.chunk_end_i          = 1'b1;
    bus.rd_req_i             = 1'b1;
    bus.rd_sparsemap_addr_i  = 4'd0;
    bus.pri_enc_match_addr_i = 3'd0;
    @(posedge clk); #1;
    bus.refresh_mem_i = 1'b0;
    bus.chunk_end_i   = 1'b0;
    bus.rd_req_i      = 1'b0;
    @(negedge clk);
    chk("e_banks",    32'(bus.dbg_bank_state_o), 0);
    chk("e_wr_bank",  32'(bus.dbg_wr_bank_o), 0);
    chk("e_rd_bank",  32'(bus.dbg_rd_bank_o), 0);
    chk("e_wr_beat",  32'(bus.dbg_wr_beat_o), 0);
    chk("e_wr_ptr",   32'(bus.dbg_wr_ptr_o), 0);
    chk("e_rd_valid", 32'(bus.rd_valid_o), 0);
    chk("e_wr_ready", 32'(bus.wr_ready_o), 1);
    chk("e_rd_ready", 32'(bus.rd_ready_o), 0);
    @(posedge clk); #1;
    wr_beat(16'h0001, mk_data(8'hAB, 1));
    wr_zero_beats(7);
    @(negedge clk);
    chk("e_refill_rd_ready", 32'(bus.rd_ready_o), 1);
    @(posedge clk); #1;
    rd_issue(4'd0, 3'd0, 8'h01, 8'd0, 8'hAB);
    rd_issue(4'd0, 3'd1, 8'h01, 8'd1, 8'h00);

    // asynchronous reset mid-fill
    wr_zero_beats(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("f_rst_banks",    32'(bus.dbg_bank_state_o), 0);
    chk("f_rst_wr_beat",  32'(bus.dbg_wr_beat_o), 0);
    chk("f_rst_wr_bank",  32'(bus.dbg_wr_bank_o), 0);
    chk("f_rst_wr_ready", 32'(bus.wr_ready_o), 1);
    chk("f_rst_rd_ready", 32'(bus.rd_ready_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
